// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer path (scheduler and timing generator).
package vga_pkg;

   localparam int H_WORDS_DEF    = 640;
   localparam int V_LINES_DEF    = 480;
   localparam int FB_ADDR_W      = 19;
   localparam int FB_DATA_W      = 16;
   localparam int STARVE_MAX_DEF = 64;
   localparam int LB_IDX_W       = 10;

   // 640x480@60Hz timing, shared with the timing generator
   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Line fetch address generator: latches the line base, walks the word index and flags the last word.
module vga_fb_addr_gen
   import vga_pkg::*;
#(
   parameter int H_WORDS = H_WORDS_DEF,
   parameter int ADDR_W  = FB_ADDR_W
)(
   input  logic                clk_i,
   input  logic                reset_ni,
   input  logic                i_load,
   input  logic [LB_IDX_W-1:0] i_line,
   input  logic                i_adv,
   output logic [LB_IDX_W-1:0] o_idx,
   output logic [ADDR_W-1:0]   o_addr,
   output logic                o_last
);

   logic [ADDR_W-1:0]   r_base;
   logic [LB_IDX_W-1:0] r_idx;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_base <= '0;
         r_idx  <= '0;
      end else if (i_load) begin
         r_base <= ADDR_W'(i_line) * ADDR_W'(H_WORDS);
         r_idx  <= '0;
      end else if (i_adv && !o_last) begin
         r_idx <= r_idx + 1'b1;
      end
   end

   // Index saturates on the last word so it can never run past the line
   assign o_last = (r_idx == LB_IDX_W'(H_WORDS - 1));
   assign o_idx  = r_idx;
   assign o_addr = r_base + ADDR_W'(r_idx);

endmodule

// File: rtl/vga_fb_scheduler.sv
// Single-port framebuffer arbiter: line prefetch has priority, the pixel writer takes idle cycles.
// Build option VGA_FB_STARVE_GUARD_EN lets a long-waiting writer steal one fetch cycle.
//
//   state | meaning
//   IDLE  | no fetch; writer may be granted
//   FETCH | one RAM read per cycle, base+idx
//   DRAIN | last line-buffer write; writer may be granted
module vga_fb_scheduler
   import vga_pkg::*;
#(
   parameter int H_WORDS    = H_WORDS_DEF,
   parameter int V_LINES    = V_LINES_DEF,
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int STARVE_MAX = STARVE_MAX_DEF
)(
   input  logic                clk_i,
   input  logic                reset_ni,
   input  logic                fetch_start_i,
   input  logic [LB_IDX_W-1:0] fetch_line_i,
   output logic                fetch_busy_o,
   output logic                overrun_o,
   output logic                lb_we_o,
   output logic [LB_IDX_W-1:0] lb_addr_o,
   output logic [DATA_W-1:0]   lb_wdata_o,
   input  logic                wr_valid_i,
   output logic                wr_ready_o,
   input  logic [ADDR_W-1:0]   wr_addr_i,
   input  logic [DATA_W-1:0]   wr_data_i,
   output logic                mem_en_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic [DATA_W-1:0]   mem_rdata_i
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_start_ok;
   logic                w_issue;
   logic                w_load;
   logic                w_steal;
   logic                w_grant;
   logic                r_active;
   logic                r_lb_we;
   logic [LB_IDX_W-1:0] r_lb_addr;
   logic [LB_IDX_W-1:0] w_idx;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic                w_last;

   vga_fb_addr_gen #(
      .H_WORDS (H_WORDS),
      .ADDR_W  (ADDR_W)
   ) u_addr_gen (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .i_load   (w_load),
      .i_line   (fetch_line_i),
      .i_adv    (w_issue),
      .o_idx    (w_idx),
      .o_addr   (w_rd_addr),
      .o_last   (w_last)
   );

   assign w_start_ok = (r_state == IDLE) && fetch_start_i &&
                       (fetch_line_i < LB_IDX_W'(V_LINES));

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) r_state <= IDLE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_load      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_start_ok) begin
               w_state_nxt = FETCH;
               w_load      = 1'b1;
            end
         end
         FETCH: begin
            if (!w_steal) begin
               w_issue = 1'b1;
               if (w_last) w_state_nxt = DRAIN;
            end
         end
         DRAIN:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef VGA_FB_STARVE_GUARD_EN
   localparam int WAIT_W = $clog2(STARVE_MAX + 1);
   logic [WAIT_W-1:0] r_wait;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_wait <= '0;
      end else if (w_grant) begin
         r_wait <= '0;
      end else if (wr_valid_i && !wr_ready_o && (r_wait < WAIT_W'(STARVE_MAX))) begin
         r_wait <= r_wait + 1'b1;
      end
   end

   assign w_steal = (r_state == FETCH) && wr_valid_i && (r_wait >= WAIT_W'(STARVE_MAX));
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^STARVE_MAX;
   assign w_steal      = 1'b0;
`endif

   // r_active keeps the combinational grant low while reset is held
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) r_active <= 1'b0;
      else           r_active <= 1'b1;
   end

   assign wr_ready_o = r_active &&
                       (((r_state == IDLE) && !w_start_ok) || (r_state == DRAIN) || w_steal);
   assign w_grant    = wr_valid_i && wr_ready_o;

   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (w_issue) begin
         mem_en_o   = 1'b1;
         mem_addr_o = w_rd_addr;
      end else if (w_grant) begin
         mem_en_o    = 1'b1;
         mem_we_o    = 1'b1;
         mem_addr_o  = wr_addr_i;
         mem_wdata_o = wr_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_lb_we   <= 1'b0;
         r_lb_addr <= '0;
      end else begin
         r_lb_we <= w_issue;
         if (w_issue) r_lb_addr <= w_idx;
      end
   end

   assign fetch_busy_o = (r_state != IDLE);
   assign overrun_o    = fetch_start_i && (r_state != IDLE);
   assign lb_we_o      = r_lb_we;
   assign lb_addr_o    = r_lb_addr;
   assign lb_wdata_o   = r_lb_we ? mem_rdata_i : '0;

endmodule
